// File: rtl/dmem_port_pkg.sv
// Shared definitions for the memory port sequencer: state encoding and owner ids.
package dmem_port_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/dmem_port_prio.sv
// Grant decision between fetch and data, with a guard that keeps a waiting
// fetch from being starved by back-to-back data requests.
module dmem_port_prio
    import dmem_port_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic grant,
    output logic owner
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    // Data wins ties unless fetch has already waited through STARVE_LIMIT data grants
    always_comb begin
        owner = OWN_D;
        if (if_req && (!d_req || starve_cnt == CNT_W'(STARVE_LIMIT))) begin
            owner = OWN_IF;
        end
    end

    // Count consecutive data grants while fetch is waiting; saturates at the limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!if_req) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (owner == OWN_IF) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Sequencer for the single memory port shared by instruction fetch and data access.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | sample requests, latch the winner's payload
// ISSUE     | mem_req_valid high, payload held until mem_req_ready
// WAIT_RESP | waiting for read data, timeout counter running
// DONE      | owner's done pulse is high for this single cycle
module dmem_port_ctrl
    import dmem_port_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int RESP_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_done,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic                d_done,
    output logic [DATA_W-1:0]   rdata,
    output logic                stall,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic                err
);

    localparam int TMO_W = $clog2(RESP_TIMEOUT + 1);

    state_t           state;
    logic             owner_q;
    logic             grant_owner;
    logic             grant;
    logic [TMO_W-1:0] tmo_cnt;

    // A grant happens only in IDLE; DONE never samples requests
    assign grant = (state == IDLE) && (if_req || d_req);

    dmem_port_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .d_req  (d_req),
        .grant  (grant),
        .owner  (grant_owner)
    );

    // Hold each requester until its own done pulse
    assign stall = (if_req & ~if_done) | (d_req & ~d_done);

    // Port sequencer; done pulses default low so they last exactly the DONE cycle.
    // The timeout is a down-counter loaded on the handshake, expiring at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            owner_q       <= OWN_IF;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            if_done       <= 1'b0;
            d_done        <= 1'b0;
            rdata         <= '0;
            err           <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner_q       <= grant_owner;
                        mem_req_valid <= 1'b1;
                        if (grant_owner == OWN_D) begin
                            mem_req_we    <= d_we;
                            mem_req_addr  <= d_addr;
                            mem_req_wdata <= d_wdata;
                            mem_req_wmask <= d_wmask;
                        end else begin
                            mem_req_we    <= 1'b0;
                            mem_req_addr  <= if_addr;
                            mem_req_wdata <= '0;
                            mem_req_wmask <= '0;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (mem_req_we) begin
                            d_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            tmo_cnt <= TMO_W'(RESP_TIMEOUT - 1);
                            state   <= WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (mem_resp_valid || tmo_cnt == '0) begin
                        rdata <= mem_resp_valid ? mem_resp_data : '0;
                        if (!mem_resp_valid) begin
                            err <= 1'b1;
                        end
                        if (owner_q == OWN_D) begin
                            d_done <= 1'b1;
                        end else begin
                            if_done <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
